// File: rtl/gh_pkg.sv
// Shared state encoding, 50 MHz timing defaults and counter-width helper
// for the button conditioner.
package gh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  localparam int unsigned DEF_STABLE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY  = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD = 5000000;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  localparam int unsigned DEF_CNT_W =
    cnt_width(DEF_STABLE_CYCLES, DEF_REPEAT_DELAY, DEF_REPEAT_PERIOD);

endpackage

// File: rtl/button_conditioner_debounce_core.sv
// Two-flop synchronizer, stable-sample debouncer and registered edge pulses.
// BTN_INVERT_EN: raw pin is active-low; sync flops keep pin polarity, reset to 1.
module debounce_core
  import gh_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = cnt_width(STABLE_CYCLES, 1, 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_rise_nxt,
  output logic o_fall_nxt
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic             w_active;
  logic             w_differ;
  logic             w_accept;

  // Flops carry pin polarity so the reset value always reads as "released".
`ifdef BTN_INVERT_EN
  localparam logic SYNC_RST = 1'b1;
  assign w_active = ~r_sync2;
`else
  localparam logic SYNC_RST = 1'b0;
  assign w_active = r_sync2;
`endif

  assign w_differ   = (w_active != r_level);
  assign w_accept   = w_differ && (r_cnt == STABLE_LAST);
  assign o_rise_nxt = w_accept &&  w_active;
  assign o_fall_nxt = w_accept && !w_active;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= SYNC_RST;
      r_sync2 <= SYNC_RST;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
      r_rise  <= o_rise_nxt;
      r_fall  <= o_fall_nxt;
      if (w_accept) begin
        r_level <= w_active;
        r_cnt   <= '0;
      end else if (w_differ) begin
        r_cnt   <= r_cnt + 1'b1;
      end else begin
        r_cnt   <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/button_conditioner.sv
// Debounced button level, press/release pulses and trigger-gated auto-repeat.
// BTN_INVERT_EN selects an active-low raw button (handled in debounce_core).
//
// state     | meaning
// ST_IDLE   | button released, no repeat activity
// ST_DELAY  | held; counts trigger-high cycles toward the first repeat
// ST_REPEAT | held; emits a repeat pulse every REPEAT_PERIOD cycles
module button_conditioner
  import gh_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic trigger,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic evt_pulse
);

  localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  rep_state_t       r_state;
  rep_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_rcnt;
  logic [CNT_W-1:0] w_rcnt_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic             w_repeat;
  logic             r_evt;

  debounce_core #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_debounce (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_btn_raw  (btn_raw),
    .o_level    (btn_level),
    .o_rise     (press_pulse),
    .o_fall     (release_pulse),
    .o_rise_nxt (w_rise_nxt),
    .o_fall_nxt (w_fall_nxt)
  );

  // FSM steps on the same edge the debounced level changes, keeping evt aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rcnt  <= '0;
      r_evt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_evt   <= w_rise_nxt | w_repeat;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_fall_nxt) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_rise_nxt) w_state_nxt = ST_DELAY;
        ST_DELAY:  if (trigger && (r_rcnt == DELAY_LAST)) w_state_nxt = ST_REPEAT;
        ST_REPEAT: if (!trigger) w_state_nxt = ST_DELAY;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // A coincident release suppresses the repeat pulse and clears the count.
  always_comb begin
    w_repeat   = 1'b0;
    w_rcnt_nxt = '0;
    if (!w_fall_nxt) begin
      case (r_state)
        ST_DELAY: begin
          if (trigger) begin
            if (r_rcnt == DELAY_LAST) w_repeat   = 1'b1;
            else                      w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (trigger) begin
            if (r_rcnt == PERIOD_LAST) w_repeat   = 1'b1;
            else                       w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign evt_pulse = r_evt;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner with a rule-level model.
module tb_button_conditioner;

  localparam int S = 4;
  localparam int D = 10;
  localparam int P = 5;
  localparam int HN = 4096;
`ifdef BTN_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif
  localparam bit ON  = ~INV;
  localparam bit OFF = INV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = OFF;
  logic trigger = 1'b0;
  logic btn_level, press_pulse, release_pulse, evt_pulse;

  button_conditioner #(
    .STABLE_CYCLES (S),
    .REPEAT_DELAY  (D),
    .REPEAT_PERIOD (P)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .trigger       (trigger),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .evt_pulse     (evt_pulse)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int edge_n   = -1;
  int last_rst = -1000;
  bit hist [HN];
  bit m_valid = 1'b0;
  bit m_level, m_press, m_rel, m_evt, m_rep;
  int m_run, m_acc;
  int press_q[$], rel_q[$], evt_q[$];
  int got[$];
  int exp_off[5] = '{0, 10, 15, 20, 25};

  // One clock: apply the rules to the inputs seen at the edge, then compare.
  task automatic tick();
    bit seen;
    @(posedge clk);
    edge_n++;
    hist[edge_n % HN] = INV ? ~btn_raw : btn_raw;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_evt   = 1'b0;
    if (rst) begin
      last_rst = edge_n;
      m_valid  = 1'b1;
      m_level  = 1'b0;
      m_run    = 0;
      m_acc    = 0;
      m_rep    = 1'b0;
    end else begin
      if (edge_n >= 2 && edge_n - 2 > last_rst) seen = hist[(edge_n - 2) % HN];
      else seen = 1'b0;
      if (seen != m_level) m_run++;
      else m_run = 0;
      if (m_run == S) begin
        m_run   = 0;
        m_level = seen;
        if (seen) begin
          m_press = 1'b1;
          m_acc   = 0;
          m_rep   = 1'b0;
        end else begin
          m_rel = 1'b1;
        end
      end else if (m_level) begin
        if (!trigger) begin
          m_acc = 0;
          m_rep = 1'b0;
        end else begin
          m_acc++;
          if (m_acc == (m_rep ? P : D)) begin
            m_evt = 1'b1;
            m_acc = 0;
            m_rep = 1'b1;
          end
        end
      end
      m_evt = m_evt | m_press;
    end
    @(negedge clk);
    if (m_valid) begin
      n_assert++;
      if ({btn_level, press_pulse, release_pulse, evt_pulse} !==
          {m_level, m_press, m_rel, m_evt}) begin
        n_fail++;
        $display("FAIL cycle_cmp edge %0d: dut lvl/prs/rel/evt=%b%b%b%b required %b%b%b%b",
                 edge_n, btn_level, press_pulse, release_pulse, evt_pulse,
                 m_level, m_press, m_rel, m_evt);
      end
    end
    if (press_pulse === 1'b1)   press_q.push_back(edge_n);
    if (release_pulse === 1'b1) rel_q.push_back(edge_n);
    if (evt_pulse === 1'b1)     evt_q.push_back(edge_n);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int first_at(input int q[$], input int lo);
    for (int i = 0; i < q.size(); i++) if (q[i] >= lo) return q[i];
    return -1;
  endfunction

  function automatic int count_in(input int q[$], input int lo, input int hi);
    int n = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] >= lo && q[i] <= hi) n++;
    return n;
  endfunction

  task automatic wait_press(input int t0, output int pe);
    pe = -1;
    for (int i = 0; i < 20 && pe < 0; i++) begin
      tick();
      pe = first_at(press_q, t0);
    end
    check("press_seen", int'(pe >= 0), 1);
  endtask

  initial begin
    int t0, pe, r, len;

    repeat (3) tick();
    check("reset_level", int'(btn_level), 0);
    check("reset_pulses", int'({press_pulse, release_pulse, evt_pulse}), 0);
    rst = 1'b0;
    t0  = edge_n + 1;
    repeat (10) tick();
    check("post_reset_no_evt", count_in(evt_q, t0, edge_n) + count_in(press_q, t0, edge_n), 0);

    // clean press and release
    t0 = edge_n + 1;
    btn_raw = ON;
    repeat (12) tick();
    check("press_latency", first_at(press_q, t0), t0 + 5);
    check("press_evt", first_at(evt_q, t0), t0 + 5);
    check("press_once", count_in(press_q, t0, edge_n), 1);
    check("press_no_release", count_in(rel_q, t0, edge_n), 0);
    check("press_level", int'(btn_level), 1);
    t0 = edge_n + 1;
    btn_raw = OFF;
    repeat (10) tick();
    check("release_latency", first_at(rel_q, t0), t0 + 5);
    check("release_no_evt", count_in(evt_q, t0, edge_n), 0);

    // bounce
    t0 = edge_n + 1;
    for (int i = 0; i < 20; i++) begin
      btn_raw = (i % 2 == 0) ? ON : OFF;
      tick();
    end
    btn_raw = OFF;
    repeat (10) tick();
    check("bounce_pulses", count_in(press_q, t0, edge_n) + count_in(rel_q, t0, edge_n)
                         + count_in(evt_q, t0, edge_n), 0);
    check("bounce_level", int'(btn_level), 0);

    // auto-repeat; release lands on the +30 repeat slot and must suppress it
    trigger = 1'b1;
    t0 = edge_n + 1;
    btn_raw = ON;
    wait_press(t0, pe);
    while (edge_n < pe + 24) tick();
    btn_raw = OFF;
    while (edge_n < pe + 40) tick();
    got.delete();
    for (int i = 0; i < evt_q.size(); i++)
      if (evt_q[i] >= pe && evt_q[i] <= pe + 30) got.push_back(evt_q[i] - pe);
    check("ar_evt_count", got.size(), 5);
    for (int k = 0; k < 5; k++)
      check($sformatf("ar_evt_off%0d", k), (k < got.size()) ? got[k] : -1, exp_off[k]);
    check("ar_release", first_at(rel_q, pe), pe + 30);
    check("ar_no_evt_after", count_in(evt_q, pe + 26, edge_n), 0);
    trigger = 1'b0;

    // trigger low hold, trigger raised after hold cycle 20
    t0 = edge_n + 1;
    btn_raw = ON;
    wait_press(t0, pe);
    while (edge_n < pe + 20) tick();
    trigger = 1'b1;
    while (edge_n < pe + 34) tick();
    btn_raw = OFF;
    while (edge_n < pe + 50) tick();
    check("tl_single_evt", count_in(evt_q, pe, pe + 29), 1);
    check("tl_first_repeat", first_at(evt_q, pe + 1), pe + 30);
    check("tl_total_evt", count_in(evt_q, pe, edge_n), 3);
    check("tl_release", first_at(rel_q, pe), pe + 40);
    trigger = 1'b0;

    // reset while repeating
    trigger = 1'b1;
    t0 = edge_n + 1;
    btn_raw = ON;
    wait_press(t0, pe);
    while (edge_n < pe + 17) tick();
    rst = 1'b1;
    tick();
    r = edge_n;
    check("rst_level", int'(btn_level), 0);
    check("rst_pulses", int'({press_pulse, release_pulse, evt_pulse}), 0);
    rst = 1'b0;
    while (edge_n < r + 12) tick();
    check("rst_quiet", count_in(evt_q, r + 1, r + 5), 0);
    check("rst_repress", first_at(press_q, r + 1), r + 6);
    btn_raw = OFF;
    trigger = 1'b0;
    repeat (12) tick();

    // randomised runs
    for (int i = 0; i < 300; i++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
      btn_raw = 1'($urandom_range(0, 1));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 15) == 0) trigger = ~trigger;
        rst = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    rst = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
